// File: rtl/ram_pkg.sv
// Shared definitions for the bidirectional single-port scratch RAM.
// Contents: default geometry, depth helper, and the bus-mode decode
// (IDLE / WRITE / READ) derived from rst / CE / WR / OE.
package ram_pkg;

  localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  // Number of words addressed by an addr_width-bit address.
  function automatic int unsigned ram_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } bus_mode_e;

  // Write wins over read when WR and OE are both high; reset and CE=0 idle the bus.
  function automatic bus_mode_e bus_mode(input logic rst,
                                         input logic ce,
                                         input logic wr,
                                         input logic oe);
    bus_mode_e mode;
    mode = IDLE;
    if (!rst && ce) begin
      if (wr) begin
        mode = WRITE;
      end else if (oe) begin
        mode = READ;
      end
    end
    return mode;
  endfunction

endpackage

// File: rtl/bidir_ram_io.sv
// Tri-state pad logic for the RAM data bus.
// Ports:
//   out_en   - drive out_data onto data when high, otherwise release (Z)
//   out_data - word to drive during a read
//   in_data  - current bus value, used by the write path
//   data     - shared bidirectional data bus
module bidir_ram_io #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  out_en,
  input  logic [DATA_WIDTH-1:0] out_data,
  output logic [DATA_WIDTH-1:0] in_data,
  inout  wire  [DATA_WIDTH-1:0] data
);

  // Drive only when enabled; otherwise leave the bus to other agents.
  assign data    = out_en ? out_data : {DATA_WIDTH{1'bz}};
  assign in_data = data;

endmodule

// File: rtl/bidir_sync_ram.sv
// Single-port SRAM on a shared tri-state data bus.
// Writes commit on the rising clk edge when CE=1 and WR=1; reads are
// combinational when CE=1, OE=1, WR=0. Synchronous active-high rst clears
// every word in one cycle and releases the bus.
// Optional build macro RAM_READ_REG_EN: read data is registered, giving one
// cycle of read latency; the bus is driven in the cycle after the read
// condition was sampled true.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   CE, WR, OE - chip enable, write strobe, output enable
//   addr      - word address (full depth, no wrap)
//   data      - bidirectional data bus
module bidir_sync_ram
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  CE,
  input  logic                  WR,
  input  logic                  OE,
  input  logic [ADDR_WIDTH-1:0] addr,
  inout  wire  [DATA_WIDTH-1:0] data
);

  localparam int unsigned DEPTH = ram_depth(ADDR_WIDTH);

  bus_mode_e             mode_c;
  logic [DATA_WIDTH-1:0] wr_data_c;
  logic [DATA_WIDTH-1:0] rd_data_c;
  logic                  out_en_c;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  assign mode_c = bus_mode(rst, CE, WR, OE);

  // Storage: full clear on reset, otherwise capture the bus on a write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[ADDR_WIDTH'(i)] <= '0;
      end
    end else if (mode_c == WRITE) begin
      mem_q[addr] <= wr_data_c;
    end
  end

`ifdef RAM_READ_REG_EN
  logic [DATA_WIDTH-1:0] rd_q;
  logic [DATA_WIDTH-1:0] rd_d;
  logic                  rd_vld_q;
  logic                  rd_vld_d;

  // Read register next state: sample the addressed word when a read is requested.
  always_comb begin
    rd_d     = rd_q;
    rd_vld_d = 1'b0;
    if (mode_c == READ) begin
      rd_d     = mem_q[addr];
      rd_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q     <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // A current write or reset still forces release so an external writer never sees contention.
  assign out_en_c  = rd_vld_q && !rst && (mode_c != WRITE);
  assign rd_data_c = rd_q;
`else
  assign out_en_c  = (mode_c == READ);
  assign rd_data_c = mem_q[addr];
`endif

  bidir_ram_io #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_io (
    .out_en  (out_en_c),
    .out_data(rd_data_c),
    .in_data (wr_data_c),
    .data    (data)
  );

endmodule

// File: tb/tb_bidir_sync_ram.sv
// Scoreboard bench for bidir_sync_ram. The bus is a pulled-up net, so a
// released bus reads all ones; stored test data never uses 8'hFF.
module tb_bidir_sync_ram;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 8;
  localparam int unsigned DEPTH = 32;
  localparam logic [DW-1:0] RELEASED = 8'hFF;

  logic          clk;
  logic          rst;
  logic          CE;
  logic          WR;
  logic          OE;
  logic [AW-1:0] addr;
  logic          drv_en;
  logic [DW-1:0] drv_data;
  tri1  [DW-1:0] data_bus;

  assign data_bus = drv_en ? drv_data : {DW{1'bz}};

  bidir_sync_ram #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .CE  (CE),
    .WR  (WR),
    .OE  (OE),
    .addr(addr),
    .data(data_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] val;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  logic [DW-1:0] model_mem [DEPTH];
  bit            pend_valid = 1'b0;
  logic [DW-1:0] pend_data  = '0;

  // Monitor: one expectation per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (data_bus === e.val) begin
        n_pass++;
      end else begin
        $display("FAIL %s: bus=%h expected=%h", e.name, data_bus, e.val);
      end
    end
  end

  // One bus cycle: apply controls, predict the bus, advance the model across the edge.
  task automatic cyc(input logic r, input logic ce, input logic wr, input logic oe,
                     input logic [AW-1:0] a, input logic [DW-1:0] d, input string nm);
    exp_t e;
    bit   ram_drives;
    rst = r; CE = ce; WR = wr; OE = oe; addr = a;
    drv_en = wr; drv_data = d;

`ifdef RAM_READ_REG_EN
    ram_drives = pend_valid && !r && !(ce && wr);
    e.val = wr ? d : (ram_drives ? pend_data : RELEASED);
`else
    ram_drives = !r && ce && oe && !wr;
    e.val = wr ? d : (ram_drives ? model_mem[a] : RELEASED);
`endif
    e.name = nm;
    exp_q.push_back(e);

    if (r) begin
      foreach (model_mem[i]) model_mem[i] = '0;
      pend_valid = 1'b0;
      pend_data  = '0;
    end else begin
      pend_valid = ce && oe && !wr;
      if (pend_valid) pend_data = model_mem[a];
      if (ce && wr) model_mem[a] = d;
    end

    @(posedge clk);
    #1;
  endtask

  initial begin
    int wait_cycles;
    rst = 1'b0; CE = 1'b0; WR = 1'b0; OE = 1'b0; addr = '0;
    drv_en = 1'b0; drv_data = '0;
    @(posedge clk);
    #1;

    // Reset then writes and read-back
    cyc(1, 0, 0, 0, 5'd0,  8'd0,  "reset_release");
    cyc(0, 1, 1, 0, 5'd3,  8'd12, "wr3");
    cyc(0, 1, 1, 0, 5'd5,  8'd6,  "wr5");
    cyc(0, 1, 1, 0, 5'd4,  8'd9,  "wr4");
    cyc(0, 1, 0, 1, 5'd3,  8'd0,  "rd3");
    cyc(0, 1, 0, 1, 5'd5,  8'd0,  "rd5");
    cyc(0, 1, 0, 1, 5'd4,  8'd0,  "rd4");
    // Unwritten words
    cyc(0, 1, 0, 1, 5'd7,  8'd0,  "rd7_unwritten");
    cyc(0, 1, 0, 1, 5'd0,  8'd0,  "rd0_unwritten");
    cyc(0, 1, 0, 1, 5'd31, 8'd0,  "rd31_unwritten");
    // Bus release and CE=0 write blocking
    cyc(0, 0, 0, 1, 5'd3,  8'd0,  "ce0_release");
    cyc(0, 0, 1, 0, 5'd3,  8'd55, "ce0_write_ignored");
    cyc(0, 1, 0, 0, 5'd3,  8'd0,  "oe0_release");
    cyc(0, 1, 0, 1, 5'd3,  8'd0,  "rd3_retained");
    cyc(0, 1, 0, 0, 5'd3,  8'd0,  "rd3_retained_tail");
    // WR+OE priority
    cyc(0, 1, 1, 1, 5'd10, 8'd200, "wr_oe_priority");
    cyc(0, 1, 0, 1, 5'd10, 8'd0,  "rd10");
    cyc(0, 1, 0, 1, 5'd10, 8'd0,  "rd10_again");
    // Reset mid-operation
    cyc(1, 1, 0, 1, 5'd3,  8'd0,  "rst_mid_release");
    cyc(0, 1, 0, 1, 5'd3,  8'd0,  "rd3_after_rst");
    cyc(0, 1, 0, 1, 5'd4,  8'd0,  "rd4_after_rst");
    cyc(0, 1, 0, 1, 5'd5,  8'd0,  "rd5_after_rst");
    cyc(0, 1, 0, 0, 5'd5,  8'd0,  "post_rst_tail");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic r, ce, wr, oe;
      r  = ($urandom_range(0, 39) == 0);
      ce = ($urandom_range(0, 4) != 0);
      wr = ($urandom_range(0, 2) == 0);
      oe = ($urandom_range(0, 3) != 0);
      cyc(r, ce, wr, oe, AW'($urandom_range(0, DEPTH - 1)),
          DW'($urandom_range(0, 254)), "random");
    end
    cyc(0, 0, 0, 0, 5'd0, 8'd0, "final_idle");

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: pending=%0d expected=0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bidir_sync_ram.md
Name: bidir_sync_ram

Overview:
- Single-port static RAM with one shared bidirectional data bus.
- Control is chip-enable / write / output-enable style.
- Writes are synchronous to the clock. Reads drive the bus combinationally from the addressed word; the bus is high-Z when not reading.
- Used as a small scratch memory on a shared tri-state bus.

Parameters:
- ADDR_WIDTH, 5, address bits; depth = 2**ADDR_WIDTH (32 words).
- DATA_WIDTH, 8, word and data-bus width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous active-high reset.
- CE  input  1  chip enable; when low, the block ignores writes and releases the bus.
- WR  input  1  write strobe, active high.
- OE  input  1  output enable, active high.
- addr  input  ADDR_WIDTH  word address.
- data  inout  DATA_WIDTH  bidirectional data bus.

Behaviour:
- One clock; reset is synchronous and active-high. rst is sampled on the rising clk edge only.
- Reset:
  - On the edge where rst=1, every memory word is cleared to 0 in that single cycle.
  - While rst=1, no write occurs and data is high-Z regardless of CE/WR/OE.
- Write:
  - On the rising clk edge with rst=0, CE=1 and WR=1: mem[addr] <= data.
  - data is the value being driven externally on the bus at that edge.
  - Written value is readable from the following cycle.
- Read:
  - Combinational (zero-cycle latency) when CE=1, OE=1, WR=0 and rst=0: data = mem[addr].
  - An addr change updates data within the same cycle.
  - A read of a just-written address in the cycle after the write returns the new value.
- Bus release: in every other combination, data = all Z. This covers CE=0, OE=0, WR=1, or rst=1.
- Simultaneous WR=1 and OE=1 with CE=1:
  - Write has priority; the RAM never drives the bus.
  - No contention with the external writer.
- Addressing: addr spans the full depth, so there is no out-of-range case and no wrap logic.
- CE=0: memory contents are retained; no side effects.
- Write data is taken as DATA_WIDTH bits exactly; no truncation or extension.
- Unwritten words read 0 after reset. Before the first reset, contents are undefined (X in simulation).

Optional Feature:
- Macro: RAM_READ_REG_EN.
- When defined:
  - Read data is registered. On each rising edge, a read register captures mem[addr] when the read condition holds.
  - data is driven from that register during the cycle after the read condition was sampled true.
  - Read latency is one cycle.
  - The register resets to 0.
  - Output is high-Z in any cycle where the read condition was false at the previous edge.
- When undefined: combinational read as above; no read register exists.

Decomposition:
- Package ram_pkg holds:
  - DEFAULT_ADDR_WIDTH=5 and DEFAULT_DATA_WIDTH=8.
  - A depth constant/function computing 2**ADDR_WIDTH.
  - An enum-like set of bus-mode constants: IDLE, WRITE, READ, derived from CE/WR/OE.
- One natural sub-module: bidir_ram_io.
  - Tri-state driver taking an out_en and an out_data input.
  - Presents the data inout port plus a sampled in_data for the write path.
- Memory array and control decode stay in the top module.

Test Plan:
- Reset then write: rst=1 for one edge; then CE=1, WR=1, write data=12 @addr=3, data=6 @addr=5, data=9 @addr=4 on successive edges. Then WR=0, OE=1: addr=3 -> data=12; addr=5 -> data=6; addr=4 -> data=9.
- Unwritten location: after reset, CE=1, OE=1, WR=0, addr=7 -> data=0. Repeat for addr=0 and addr=31 -> 0.
- Bus release: CE=0 with OE=1, addr=3 -> data=Z; a WR=1 edge with CE=0, data=55, addr=3 leaves mem[3]=12. OE=0 with CE=1 -> data=Z.
- Priority: CE=1, WR=1, OE=1, external data=200, addr=10 -> RAM drives Z during the cycle; a later read of addr=10 -> 200.
- Reset mid-operation: after the writes above, assert rst=1 with CE=1, OE=1 -> data=Z during reset. After deassertion, reads of addr 3/4/5 -> 0.
- RAM_READ_REG_EN build: read addr=3 (=12) -> data Z in the first cycle, then 12 one cycle later. Changing addr 3->5 produces 6 one cycle after the change.
